spike_count_ram: RTL and testbench
==================================

# spike_count_ram

Parametrised per-channel spike-count memory for the event-driven MUA front end. Each spike event increments a saturating counter for its channel through a pipelined read-modify-write. A readout port returns a channel's count, with optional clear-on-read, so the binning/compression stage can drain rates window by window. After reset a sweep zeroes the memory, so no memory initialisation file is needed.

## Interface
- CH_NUM, 512: number of channels (memory depth); any value ≥ 2.
- CH_BIT, $clog2(CH_NUM): channel address width.
- CNT_WIDTH, 8: counter width per channel; saturates at 2^CNT_WIDTH−1.
- CLEAR_ON_READ, 1: 1 = an accepted read zeroes the channel; 0 = the read is non-destructive.

- clk, in, 1: single clock; all logic is on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- clear_all, in, 1: one-cycle pulse that restarts the zeroing sweep.
- ev_valid, in, 1: a spike event is present this cycle.
- ev_ch, in, CH_BIT: channel of the event.
- ev_drop, out, 1: one-cycle pulse when ev_valid is high while busy (event discarded).
- rd_req, in, 1: readout request; holds with rd_ch stable until rd_ack.
- rd_ch, in, CH_BIT: channel to read.
- rd_ack, out, 1: combinational; the request is accepted this cycle.
- rd_valid, out, 1: one-cycle pulse; rd_data is valid.
- rd_data, out, CNT_WIDTH: count returned.
- rd_sat, out, 1: qualifies rd_data; high when the count is at its maximum.
- busy, out, 1: the zeroing sweep is in progress.

## Operation
- States:
  - INIT: writes 0 to addresses 0..CH_NUM−1, one per cycle. It is entered on reset and on clear_all. It exits to RUN after address CH_NUM−1 is written.
  - RUN: normal operation.
- clear_all while in INIT restarts the sweep at address 0.
- In INIT:
  - ev_valid produces ev_drop=1 and no count change.
  - rd_ack=0.
- Event acceptance: in RUN, every ev_valid is accepted; events are never stalled.
- Read acceptance:
  - rd_ack = rd_req & RUN & (!ev_valid | ev_ch==rd_ch).
  - Events have priority over reads.
  - A read and an event on the same channel form one combined operation.
- Semantics of an event accepted at cycle T: the channel's count becomes min(count+1, 2^CNT_WIDTH−1).
- Semantics of a read accepted at T:
  - rd_data is the count including every event accepted before T and excluding any event at T.
  - With CLEAR_ON_READ=1, the count afterwards is 1 if a same-channel event was accepted at T, otherwise 0.
  - With CLEAR_ON_READ=0, the event at T still increments the count.
- Back-to-back events on the same channel at T and T+1 must both count. The pipeline forwards the stage-2 write value to any stage-1 access on the same channel; there is no stall and no lost increment.
- A read accepted one cycle after an event on the same channel returns the forwarded post-event value. The same holds for a clear followed by an event.
- Saturation:
  - Counts never wrap.
  - rd_sat = (rd_data == 2^CNT_WIDTH−1).
- Reset mid-operation: in-flight RMWs and pending reads are discarded, and INIT is re-entered.

## Timing
- Reset values: rd_valid=0, rd_data=0, rd_sat=0, ev_drop=0, busy=1, rd_ack=0.
- INIT lasts exactly CH_NUM cycles after rst_n deasserts: busy falls on the clock edge after address CH_NUM−1 is written.
- clear_all sampled at cycle T: busy=1 from T+1, and the sweep occupies CH_NUM cycles.
- Event RMW pipeline:
  - Memory read at T.
  - Increment and write at T+1.
  - The new value is visible to an access at T+1 via forwarding.
- Read latency: accepted at T → rd_valid=1 with rd_data and rd_sat at T+2. Reads may be accepted every cycle, giving a fully pipelined throughput of 1 per cycle.
- ev_drop is registered and asserts the cycle after the dropped ev_valid.
- rd_ack is combinational from rd_req, rd_ch, ev_valid, ev_ch and state; it has no registered delay.

## Test plan
- Reset with CH_NUM=512 → busy=1 for 512 cycles. Then a read of every channel → rd_data=0 for all, and rd_valid exactly 2 cycles after each rd_ack.
- 5 events on channel 7 in consecutive cycles, then a read → rd_data=5. With CLEAR_ON_READ=1, a second read → 0.
- CNT_WIDTH=4 with 20 events on channel 3 → rd_data=15 and rd_sat=1. No wrap to 4.
- Read of channel 9 and event on channel 9 in the same cycle, with 3 prior events:
  - rd_ack=1, rd_data=3, and a later read returns 1 (CLEAR_ON_READ=1).
  - With an event on channel 10 instead, rd_ack=0 until ev_valid drops.
- clear_all after counting channel 2 to 6, plus events during the sweep → ev_drop pulses for each event, busy lasts CH_NUM cycles, and channel 2 then reads 0.
- rst_n asserted mid-stream with a read outstanding → rd_valid stays 0, outputs take their reset values, and the full INIT sweep repeats.

Source files
------------

// File: rtl/spike_count_ram.sv
// Per-channel saturating spike-count memory.
// Events run a two-stage read-modify-write: the memory is read in stage 1 and
// the incremented value is written in stage 2. A stage-2 write to the same
// channel is forwarded into stage 1, so back-to-back events never lose counts.
// The readout port shares stage 1 and can clear the channel on read. After
// reset or clear_all, an INIT sweep zeroes the whole memory.
module spike_count_ram #(
  parameter int CH_NUM        = 512,
  parameter int CH_BIT        = $clog2(CH_NUM),
  parameter int CNT_WIDTH     = 8,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_all,
  input  logic                 ev_valid,
  input  logic [CH_BIT-1:0]    ev_ch,
  output logic                 ev_drop,
  input  logic                 rd_req,
  input  logic [CH_BIT-1:0]    rd_ch,
  output logic                 rd_ack,
  output logic                 rd_valid,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 rd_sat,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CH_BIT-1:0]    LAST_CH = CH_BIT'(CH_NUM - 1);

  typedef enum logic {INIT, RUN} state_t;

  // Stage-1 operation: an event and/or a read on one channel, plus the
  // (possibly forwarded) count read from memory.
  typedef struct packed {
    logic                 ev;
    logic                 rd;
    logic [CH_BIT-1:0]    ch;
    logic [CNT_WIDTH-1:0] data;
  } op_t;

  state_t               state_q, state_d;
  logic [CH_BIT-1:0]    init_addr_q, init_addr_d;
  op_t                  s1_q, s1_d;
  logic [CNT_WIDTH-1:0] mem [CH_NUM];

  logic                 run;
  logic [CH_BIT-1:0]    acc_ch;
  logic                 wr_en;
  logic                 rd_clr;
  logic [CNT_WIDTH-1:0] wr_base;
  logic [CNT_WIDTH-1:0] wr_val;
  logic [CNT_WIDTH-1:0] rd_val;

  assign run    = (state_q == RUN);
  assign busy   = ~run;
  // Events always win; a read rides along only when it hits the same channel.
  assign rd_ack = rd_req & run & (~ev_valid | (ev_ch == rd_ch));
  assign acc_ch = ev_valid ? ev_ch : rd_ch;

  // Stage-2 write value: clear (if destructive read) then saturating increment.
  assign rd_clr  = CLEAR_ON_READ ? s1_q.rd : 1'b0;
  assign wr_en   = s1_q.ev | rd_clr;
  assign wr_base = rd_clr ? '0 : s1_q.data;
  assign wr_val  = s1_q.ev ? ((wr_base == CNT_MAX) ? wr_base : wr_base + 1'b1) : wr_base;

  // Stage-1 read, bypassing the memory when stage 2 is writing the same channel.
  assign rd_val = (wr_en && (s1_q.ch == acc_ch)) ? wr_val : mem[acc_ch];

  always_comb begin
    s1_d      = '0;
    s1_d.ev   = ev_valid & run;
    s1_d.rd   = rd_ack;
    s1_d.ch   = acc_ch;
    s1_d.data = rd_val;
  end

  // Next state and sweep address; clear_all restarts the sweep from any state.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (clear_all) begin
      state_d     = INIT;
      init_addr_d = '0;
    end else if (state_q == INIT) begin
      init_addr_d = init_addr_q + 1'b1;
      if (init_addr_q == LAST_CH) begin
        state_d     = RUN;
        init_addr_d = '0;
      end
    end
  end

  // State register and sweep address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // Pipeline registers and registered outputs; reset discards in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_sat   <= 1'b0;
      ev_drop  <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      rd_valid <= s1_q.rd;
      ev_drop  <= ev_valid & ~run;
      if (s1_q.rd) begin
        rd_data <= s1_q.data;
        rd_sat  <= (s1_q.data == CNT_MAX);
      end
    end
  end

  // Single write port: the sweep owns it during INIT; anything still in stage 2
  // then is discarded because the sweep zeroes that channel anyway.
  always_ff @(posedge clk) begin
    if (!run)       mem[init_addr_q] <= '0;
    else if (wr_en) mem[s1_q.ch]     <= wr_val;
  end

endmodule

// File: tb/tb_spike_count_ram.sv
// Bench for spike_count_ram: directed scenarios followed by random traffic,
// all checked against a per-channel count array and a two-deep read queue.
module tb_spike_count_ram;

  localparam int CH_NUM    = 32;
  localparam int CH_BIT    = $clog2(CH_NUM);
  localparam int CNT_WIDTH = 4;
  localparam int MAXC      = (1 << CNT_WIDTH) - 1;

  logic                 clk, rst_n, clear_all, ev_valid, rd_req;
  logic [CH_BIT-1:0]    ev_ch, rd_ch;
  logic                 ev_drop, rd_ack, rd_valid, rd_sat, busy;
  logic [CNT_WIDTH-1:0] rd_data;

  spike_count_ram #(.CH_NUM(CH_NUM), .CNT_WIDTH(CNT_WIDTH), .CLEAR_ON_READ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clear_all(clear_all),
    .ev_valid(ev_valid), .ev_ch(ev_ch), .ev_drop(ev_drop),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_sat(rd_sat), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  int cnt [CH_NUM];
  int busy_cnt;
  bit prev_drop;
  bit q1_v, q2_v;
  int q1_d, q2_d;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH_NUM; i++) cnt[i] = 0;
    busy_cnt  = CH_NUM;
    prev_drop = 1'b0;
    q1_v = 1'b0; q2_v = 1'b0; q1_d = 0; q2_d = 0;
  endtask

  // One clock cycle: drive at negedge, check at +1, update the model, advance.
  task automatic step(input bit ev_v, input int ev_c, input bit rq, input int rc,
                      input bit clr, output bit ack);
    bit exp_busy;
    clear_all = clr; ev_valid = ev_v; ev_ch = CH_BIT'(ev_c);
    rd_req = rq; rd_ch = CH_BIT'(rc);
    #1;
    exp_busy = (busy_cnt > 0);
    ack = rq && !exp_busy && (!ev_v || ev_c == rc);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("rd_ack", 32'(rd_ack), 32'(ack));
    chk("ev_drop", 32'(ev_drop), 32'(prev_drop));
    chk("rd_valid", 32'(rd_valid), 32'(q2_v));
    if (q2_v) begin
      chk("rd_data", 32'(rd_data), 32'(q2_d));
      chk("rd_sat", 32'(rd_sat), 32'(q2_d == MAXC));
    end
    q2_v = q1_v; q2_d = q1_d;
    q1_v = ack;  q1_d = ack ? cnt[rc] : 0;
    prev_drop = ev_v && exp_busy;
    if (!exp_busy) begin
      if (ack) cnt[rc] = 0;
      if (ev_v) cnt[ev_c] = (cnt[ev_c] < MAXC) ? cnt[ev_c] + 1 : MAXC;
    end
    if (clr) begin
      busy_cnt = CH_NUM;
      for (int i = 0; i < CH_NUM; i++) cnt[i] = 0;
    end else if (busy_cnt > 0) busy_cnt--;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 1'b0, a);
  endtask

  task automatic events(input int ch, input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b1, ch, 1'b0, 0, 1'b0, a);
  endtask

  // Hold a read request until it is acknowledged, within a cycle budget.
  task automatic read_ch(input int ch);
    bit a;
    int w;
    a = 1'b0;
    w = 0;
    while (!a && w < 50) begin
      step(1'b0, 0, 1'b1, ch, 1'b0, a);
      w++;
    end
    if (!a) chk("read_timeout", 32'(w), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
    chk({tag, "_rd_data"},  32'(rd_data),  32'(0));
    chk({tag, "_rd_sat"},   32'(rd_sat),   32'(0));
    chk({tag, "_ev_drop"},  32'(ev_drop),  32'(0));
    chk({tag, "_busy"},     32'(busy),     32'(1));
    chk({tag, "_rd_ack"},   32'(rd_ack),   32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a, ev_v, hold, clr;
    int ev_c, hch;

    // Reset and full INIT sweep, then read every channel back to back.
    rst_n = 1'b0; clear_all = 1'b0; ev_valid = 1'b0; ev_ch = '0;
    rd_req = 1'b1; rd_ch = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rd_req = 1'b0;
    rst_n = 1'b1;
    idle(CH_NUM);
    for (int i = 0; i < CH_NUM; i++) step(1'b0, 0, 1'b1, i, 1'b0, a);
    idle(2);

    // Five consecutive events, read, then a second read after the clear.
    events(7, 5);
    read_ch(7);
    idle(2);
    read_ch(7);
    idle(2);

    // Saturation at 15 with 20 events.
    events(3, 20);
    read_ch(3);
    idle(2);
    read_ch(3);
    idle(2);

    // Combined read + event on the same channel, then a blocked read.
    events(9, 3);
    step(1'b1, 9, 1'b1, 9, 1'b0, a);
    idle(2);
    read_ch(9);
    events(9, 2);
    for (int i = 0; i < 3; i++) step(1'b1, 10, 1'b1, 9, 1'b0, a);
    read_ch(9);
    idle(2);

    // clear_all with events arriving during the sweep.
    events(2, 6);
    step(1'b0, 0, 1'b0, 0, 1'b1, a);
    for (int i = 0; i < CH_NUM; i++) step(i[0], 2, 1'b0, 0, 1'b0, a);
    read_ch(2);
    idle(2);

    // Random traffic concentrated on a few channels to stress forwarding.
    hold = 1'b0; hch = 0;
    for (int i = 0; i < 3000; i++) begin
      ev_v = ($urandom_range(0, 99) < 60);
      ev_c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, CH_NUM - 1))
                                         : int'($urandom_range(0, 3));
      if (!hold && $urandom_range(0, 99) < 30) begin
        hold = 1'b1;
        hch  = $urandom_range(0, 5);
      end
      clr = ($urandom_range(0, 999) == 0);
      step(ev_v, ev_c, hold, hch, clr, a);
      if (a) hold = 1'b0;
    end
    idle(CH_NUM + 2);

    // Reset while a read is in flight: its result must never appear.
    events(1, 4);
    step(1'b1, 1, 1'b1, 1, 1'b0, a);
    chk("pre_reset_ack", 32'(a), 32'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); @(negedge clk); #1;
    check_reset_outputs("midreset_hold");
    rd_req = 1'b0; ev_valid = 1'b0;
    model_reset();
    rst_n = 1'b1;
    idle(CH_NUM);
    read_ch(1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
